uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_parity_calc.sv | 13 +
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter and receiver FSM state encodings
// plus line-level constants used by both directions.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } txState_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rxState_e;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity generator shared by the UART transmitter and the receiver's checker.
// parity_o is the XOR of the word, inverted when odd parity is selected.
module uart_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  parTyp_i,
    output logic                  parity_o
);

    assign parity_o = (^data_i) ^ parTyp_i;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one TX bit per CLK cycle, optional parity, registered
// TX_OUT/BUSY; a word may be accepted in IDLE or in STOP for gapless frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    txState_e              state_q,  state_d;
    logic                  txOut_q,  txOut_d;
    logic                  busy_q,   busy_d;
    logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
    logic [DATA_WIDTH-1:0] data_q,   data_d;
    logic                  parEn_q,  parEn_d;
    logic                  parTyp_q, parTyp_d;

    logic                  accept;
    logic                  parBit;
    logic [CNT_W-1:0]      nextCnt;

    uart_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data_i  (data_q),
        .parTyp_i(parTyp_q),
        .parity_o(parBit)
    );

    assign accept  = DATA_VALID && !busy_q;
    assign nextCnt = bitCnt_q + 1'b1;

    // Outputs are computed as next-state values so they change on the same edge as the state.
    always_comb begin
        state_d  = state_q;
        txOut_d  = txOut_q;
        busy_d   = busy_q;
        bitCnt_d = bitCnt_q;
        data_d   = data_q;
        parEn_d  = parEn_q;
        parTyp_d = parTyp_q;

        case (state_q)
            TX_IDLE, TX_STOP: begin
                if (accept) begin
                    state_d  = TX_START;
                    txOut_d  = START_BIT;
                    busy_d   = 1'b1;
                    data_d   = P_DATA;
                    parEn_d  = PAR_EN;
                    parTyp_d = PAR_TYP;
                end else begin
                    state_d = TX_IDLE;
                    txOut_d = LINE_IDLE;
                    busy_d  = 1'b0;
                end
            end
            TX_START: begin
                state_d  = TX_DATA;
                txOut_d  = data_q[0];
                busy_d   = 1'b1;
                bitCnt_d = '0;
            end
            TX_DATA: begin
                if (bitCnt_q == LAST_BIT) begin
                    if (parEn_q) begin
                        state_d = TX_PARITY;
                        txOut_d = parBit;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = TX_STOP;
                        txOut_d = STOP_BIT;
                        busy_d  = 1'b0;
                    end
                end else begin
                    bitCnt_d = nextCnt;
                    txOut_d  = data_q[nextCnt];
                    busy_d   = 1'b1;
                end
            end
            TX_PARITY: begin
                state_d = TX_STOP;
                txOut_d = STOP_BIT;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = TX_IDLE;
                txOut_d = LINE_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= TX_IDLE;
            txOut_q  <= LINE_IDLE;
            busy_q   <= 1'b0;
            bitCnt_q <= '0;
            data_q   <= '0;
            parEn_q  <= 1'b0;
            parTyp_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            txOut_q  <= txOut_d;
            busy_q   <= busy_d;
            bitCnt_q <= bitCnt_d;
            data_q   <= data_d;
            parEn_q  <= parEn_d;
            parTyp_q <= parTyp_d;
        end
    end

    assign TX_OUT = txOut_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx: each task drives one scenario and compares
// TX_OUT/BUSY per bit period against hand-written frame sequences.
module tb_uart_tx;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    uart_tx #(
        .DATA_WIDTH(8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_tx: got %b expected 1", TX_OUT);
        end
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b expected 0", BUSY);
        end
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got tx=%b busy=%b expected tx=1 busy=0", TX_OUT, BUSY);
        end
    endtask

    // 0xA5 without parity, then line held idle
    task automatic test_no_parity();
        logic [0:12] expTx   = 13'b0_10100101_1_111;
        logic [0:12] expBusy = 13'b1_11111111_0_000;
        @(negedge CLK);
        P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            DATA_VALID = 1'b0;
            checks++;
            if (TX_OUT !== expTx[i]) begin
                errors++;
                $display("[TB] FAIL noParity_tx[%0d]: got %b expected %b", i, TX_OUT, expTx[i]);
            end
            checks++;
            if (BUSY !== expBusy[i]) begin
                errors++;
                $display("[TB] FAIL noParity_busy[%0d]: got %b expected %b", i, BUSY, expBusy[i]);
            end
        end
    endtask

    // 0xA5 with even then odd parity; 0xA5 has four ones
    task automatic test_parity_a5();
        logic [0:11] expTx;
        logic [0:11] expBusy = 12'b1_11111111_1_0_0;
        for (int t = 0; t < 2; t++) begin
            expTx = (t == 0) ? 12'b0_10100101_0_1_1 : 12'b0_10100101_1_1_1;
            @(negedge CLK);
            P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = t[0]; DATA_VALID = 1'b1;
            for (int i = 0; i < 12; i++) begin
                @(negedge CLK);
                DATA_VALID = 1'b0;
                PAR_TYP = ~PAR_TYP;
                checks++;
                if (TX_OUT !== expTx[i]) begin
                    errors++;
                    $display("[TB] FAIL parityA5_typ%0d_tx[%0d]: got %b expected %b", t, i, TX_OUT, expTx[i]);
                end
                checks++;
                if (BUSY !== expBusy[i]) begin
                    errors++;
                    $display("[TB] FAIL parityA5_typ%0d_busy[%0d]: got %b expected %b", t, i, BUSY, expBusy[i]);
                end
            end
        end
    endtask

    // 0x00 odd parity and 0xFF even parity
    task automatic test_parity_edges();
        logic [0:11] expTx;
        for (int t = 0; t < 2; t++) begin
            expTx = (t == 0) ? 12'b0_00000000_1_1_1 : 12'b0_11111111_0_1_1;
            @(negedge CLK);
            P_DATA = (t == 0) ? 8'h00 : 8'hFF;
            PAR_EN = 1'b1; PAR_TYP = (t == 0); DATA_VALID = 1'b1;
            for (int i = 0; i < 12; i++) begin
                @(negedge CLK);
                DATA_VALID = 1'b0;
                checks++;
                if (TX_OUT !== expTx[i]) begin
                    errors++;
                    $display("[TB] FAIL parityEdge%0d_tx[%0d]: got %b expected %b", t, i, TX_OUT, expTx[i]);
                end
            end
        end
    endtask

    // 0x55 then 0x0F with DATA_VALID held: second start right after first stop
    task automatic test_back_to_back();
        logic [0:20] expTx   = 21'b0_10101010_1_0_11110000_1_1;
        logic [0:20] expBusy = 21'b1_11111111_0_1_11111111_0_0;
        @(negedge CLK);
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        for (int i = 0; i < 21; i++) begin
            @(negedge CLK);
            P_DATA = 8'h0F;
            checks++;
            if (TX_OUT !== expTx[i]) begin
                errors++;
                $display("[TB] FAIL backToBack_tx[%0d]: got %b expected %b", i, TX_OUT, expTx[i]);
            end
            checks++;
            if (BUSY !== expBusy[i]) begin
                errors++;
                $display("[TB] FAIL backToBack_busy[%0d]: got %b expected %b", i, BUSY, expBusy[i]);
            end
            if (i == 10) DATA_VALID = 1'b0;
        end
    endtask

    // 0xFF request pulsed mid-frame must be ignored entirely
    task automatic test_ignore_busy();
        logic [0:21] expTx = 22'b0_00000000_1_111111111111;
        @(negedge CLK);
        P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge CLK);
            DATA_VALID = (i == 3);
            if (i == 3) begin
                P_DATA = 8'hFF;
                PAR_EN = 1'b1;
            end
            checks++;
            if (TX_OUT !== expTx[i]) begin
                errors++;
                $display("[TB] FAIL ignoreBusy_tx[%0d]: got %b expected %b", i, TX_OUT, expTx[i]);
            end
        end
        DATA_VALID = 1'b0;
        PAR_EN = 1'b0;
    endtask

    // reset during data bit 3 of 0xF7, then 0x3C sent from the first edge after release
    task automatic test_reset_mid_frame();
        logic [0:11] expTx   = 12'b0_00111100_1_1_1;
        logic [0:11] expBusy = 12'b1_11111111_0_0_0;
        @(negedge CLK);
        P_DATA = 8'hF7; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            DATA_VALID = 1'b0;
        end
        checks++;
        if (TX_OUT !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL preReset_bit3: got tx=%b busy=%b expected tx=0 busy=1", TX_OUT, BUSY);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (TX_OUT !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midReset_tx: got %b expected 1", TX_OUT);
        end
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midReset_busy: got %b expected 0", BUSY);
        end
        @(negedge CLK);
        RST = 1'b0;
        P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            DATA_VALID = 1'b0;
            checks++;
            if (TX_OUT !== expTx[i]) begin
                errors++;
                $display("[TB] FAIL afterReset_tx[%0d]: got %b expected %b", i, TX_OUT, expTx[i]);
            end
            checks++;
            if (BUSY !== expBusy[i]) begin
                errors++;
                $display("[TB] FAIL afterReset_busy[%0d]: got %b expected %b", i, BUSY, expBusy[i]);
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        P_DATA = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        test_reset();
        test_no_parity();
        test_parity_a5();
        test_parity_edges();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
